// File: rtl/serial_tx_framer.sv
// Parallel-to-serial framer: queues WIDTH-bit words in a small FIFO and emits each one
// MSB first with a one-cycle start strobe, followed by GAP idle cycles.
module serial_tx_framer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int GAP   = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] WR_DATA,
   input  logic             WR_VALID,
   output logic             WR_READY,
   output logic             S_START,
   output logic             S_IN,
   output logic             BUSY,
   output logic [15:0]      FRAMES_SENT
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   state_e           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [BIT_W-1:0] bit_cnt_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic             s_start_q;
   logic             s_in_q;
   logic [15:0]      frames_q;
   logic             push;
   logic             pop;
   logic             fifo_nonempty;
   logic             frame_done;

   assign WR_READY    = (count_q < FULL_CNT);
   assign BUSY        = (state_q != ST_IDLE) || fifo_nonempty;
   assign S_START     = s_start_q;
   assign S_IN        = s_in_q;
   assign FRAMES_SENT = frames_q;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      fifo_nonempty = (count_q != '0);
      push          = WR_VALID && WR_READY;
      frame_done    = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
      // A frame starts from IDLE, right after an LSB when there is no gap, or when the gap expires.
      pop = fifo_nonempty &&
            ((state_q == ST_IDLE) ||
             (frame_done && (GAP == 0)) ||
             ((state_q == ST_GAP) && (gap_cnt_q == '0)));
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: word storage is not reset; pointers and count alone decide which entries are valid.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         s_start_q <= 1'b0;
         s_in_q    <= 1'b0;
         frames_q  <= '0;
      end else begin
         // NOTE: non-blocking defaults here are overridden by later assignments in the same block.
         s_start_q <= 1'b0;
         s_in_q    <= 1'b0;
         case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
               if (bit_cnt_q != '0) begin
                  s_in_q    <= shift_q[WIDTH-1];
                  shift_q   <= shift_q << 1;
                  bit_cnt_q <= bit_cnt_q - 1'b1;
               end else begin
                  frames_q <= frames_q + 16'd1;
                  if (GAP > 0) begin
                     state_q   <= ST_GAP;
                     gap_cnt_q <= GAP_LOAD;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt_q != '0) begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if (pop) begin
            state_q   <= ST_SHIFT;
            shift_q   <= mem_q[rd_ptr_q] << 1;
            bit_cnt_q <= LAST_BIT;
            s_start_q <= 1'b1;
            s_in_q    <= mem_q[rd_ptr_q][WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Directed bench for serial_tx_framer: latency, gaps, FIFO full, GAP=0, reset mid-frame
// and FRAMES_SENT wrap on a reduced WIDTH=2 build.
module tb_serial_tx_framer;

   logic clk   = 1'b0;
   logic clk_f = 1'b0;
   always #5 clk = ~clk;
   always #1 clk_f = ~clk_f;

   logic        rst_n;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready, s_start, s_in, busy;
   logic [15:0] frames;
   logic [31:0] g0_data;
   logic        g0_valid, g0_ready, g0_s_start, g0_s_in, g0_busy;
   logic [15:0] g0_frames;
   logic [1:0]  w2_data;
   logic        w2_valid, w2_ready, w2_s_start, w2_s_in, w2_busy;
   logic [15:0] w2_frames;

   serial_tx_framer #(.WIDTH(32), .DEPTH(4), .GAP(1)) dut (
      .CLK(clk), .RESET(rst_n), .WR_DATA(wr_data), .WR_VALID(wr_valid), .WR_READY(wr_ready),
      .S_START(s_start), .S_IN(s_in), .BUSY(busy), .FRAMES_SENT(frames));

   serial_tx_framer #(.WIDTH(32), .DEPTH(4), .GAP(0)) dut_g0 (
      .CLK(clk), .RESET(rst_n), .WR_DATA(g0_data), .WR_VALID(g0_valid), .WR_READY(g0_ready),
      .S_START(g0_s_start), .S_IN(g0_s_in), .BUSY(g0_busy), .FRAMES_SENT(g0_frames));

   serial_tx_framer #(.WIDTH(2), .DEPTH(4), .GAP(0)) dut_w2 (
      .CLK(clk_f), .RESET(rst_n), .WR_DATA(w2_data), .WR_VALID(w2_valid), .WR_READY(w2_ready),
      .S_START(w2_s_start), .S_IN(w2_s_in), .BUSY(w2_busy), .FRAMES_SENT(w2_frames));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Serial receiver on the main instance: rebuilds frames and logs start cycles.
   int          cyc = 0;
   int          mon_left = 0;
   int          proto_err = 0;
   logic [31:0] mon_sr;
   int          starts[$];
   logic [31:0] words[$];

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         mon_left = 0;
      end else if (s_start) begin
         if (mon_left != 0) proto_err++;
         starts.push_back(cyc);
         mon_sr   = {31'b0, s_in};
         mon_left = 31;
      end else if (mon_left != 0) begin
         mon_sr = {mon_sr[30:0], s_in};
         mon_left--;
         if (mon_left == 0) words.push_back(mon_sr);
      end else if (s_in) begin
         proto_err++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick_f(input int n);
      repeat (n) @(negedge clk_f);
   endtask

   task automatic clear_mon();
      words.delete();
      starts.delete();
      proto_err = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      clear_mon();
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_words(input string tag, input int n, input int budget);
      int k = 0;
      while (words.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, (words.size() >= n), 1'b1);
   endtask

   task automatic check_words(input string tag, input logic [31:0] base, input int n);
      check({tag, "_count"}, words.size(), n);
      for (int k = 0; k < n; k++) begin
         if (k < words.size()) check($sformatf("%s_word%0d", tag, k), words[k], base + k);
      end
   endtask

   logic [31:0] b2b [3] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
   logic [31:0] w;
   logic [31:0] sr;
   int          n;

   initial begin
      rst_n = 1'b0;
      wr_valid = 1'b0; wr_data = '0;
      g0_valid = 1'b0; g0_data = '0;
      w2_valid = 1'b0; w2_data = '0;

      // Reset state and single-word latency / bit order
      tick(2);
      check("rst_s_start", s_start, 0);
      check("rst_s_in", s_in, 0);
      check("rst_busy", busy, 0);
      check("rst_frames", frames, 0);
      check("rst_ready", wr_ready, 1);
      clear_mon();
      rst_n = 1'b1;
      tick(1);
      w = 32'hA5A5_0F0F;
      wr_data = w; wr_valid = 1'b1;
      tick(1);
      wr_valid = 1'b0;
      check("t1_no_early_start", s_start, 0);
      check("t1_busy_queued", busy, 1);
      tick(1);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("t1_bit%0d", i), s_in, w[31-i]);
         check($sformatf("t1_start%0d", i), s_start, (i == 0));
         if (i == 31) check("t1_frames_at_lsb", frames, 0);
         tick(1);
      end
      check("t1_frames", frames, 1);
      check("t1_gap_s_in", s_in, 0);
      check("t1_gap_busy", busy, 1);
      tick(1);
      check("t1_idle_busy", busy, 0);
      check("t1_idle_frames", frames, 1);
      check("t1_mon_count", words.size(), 1);
      if (words.size() > 0) check("t1_mon_word", words[0], w);

      // Back-to-back with GAP=1
      do_reset();
      for (int k = 0; k < 3; k++) begin
         wr_data = b2b[k]; wr_valid = 1'b1;
         tick(1);
      end
      wr_valid = 1'b0;
      wait_words("t2_wait", 3, 300);
      tick(3);
      check("t2_count", words.size(), 3);
      for (int k = 0; k < 3; k++) begin
         if (k < words.size()) check($sformatf("t2_word%0d", k), words[k], b2b[k]);
      end
      if (starts.size() == 3) begin
         check("t2_spacing01", starts[1] - starts[0], 33);
         check("t2_spacing12", starts[2] - starts[1], 33);
      end
      check("t2_proto", proto_err, 0);
      check("t2_frames", frames, 3);
      check("t2_busy", busy, 0);

      // FIFO full: WR_VALID held for 8 cycles
      do_reset();
      for (int k = 0; k < 8; k++) begin
         wr_data = 32'h1000_0000 + k; wr_valid = 1'b1;
         check($sformatf("t3_ready%0d", k), wr_ready, (k < 5));
         tick(1);
      end
      wr_valid = 1'b0;
      wait_words("t3_wait", 5, 400);
      tick(40);
      check_words("t3", 32'h1000_0000, 5);
      for (int k = 1; k < starts.size(); k++) check($sformatf("t3_spacing%0d", k), starts[k] - starts[k-1], 33);
      check("t3_proto", proto_err, 0);
      check("t3_frames", frames, 5);
      check("t3_busy", busy, 0);

      // Reset at bit 10 of a frame with two words queued
      wr_data = 32'hFFFF_FFFF; wr_valid = 1'b1; tick(1);
      wr_data = 32'h1111_1111; tick(1);
      wr_data = 32'h2222_2222; tick(1);
      wr_valid = 1'b0;
      tick(9);
      check("t4_pre_s_in", s_in, 1);
      check("t4_pre_busy", busy, 1);
      check("t4_pre_frames", frames, 5);
      rst_n = 1'b0;
      #1;
      check("t4_rst_s_in", s_in, 0);
      check("t4_rst_s_start", s_start, 0);
      check("t4_rst_busy", busy, 0);
      check("t4_rst_frames", frames, 0);
      check("t4_rst_ready", wr_ready, 1);
      @(negedge clk);
      clear_mon();
      rst_n = 1'b1;
      tick(100);
      check("t4_no_frame", starts.size(), 0);
      check("t4_idle_busy", busy, 0);
      check("t4_idle_frames", frames, 0);
      wr_data = 32'h0F0F_0F0F; wr_valid = 1'b1; tick(1);
      wr_valid = 1'b0;
      wait_words("t4_wait", 1, 100);
      tick(3);
      check_words("t4_new", 32'h0F0F_0F0F, 1);
      check("t4_new_frames", frames, 1);

      // GAP=0: two words, second start exactly 32 cycles after the first
      g0_data = 32'h1234_5678; g0_valid = 1'b1; tick(1);
      g0_data = 32'h9ABC_DEF0; tick(1);
      g0_valid = 1'b0;
      n = 0;
      while (!g0_s_start && n < 50) begin
         tick(1);
         n++;
      end
      check("g0_start_seen", g0_s_start, 1);
      for (int f = 0; f < 2; f++) begin
         if (f == 1) check("g0_back_to_back", g0_s_start, 1);
         sr = '0;
         for (int i = 0; i < 32; i++) begin
            sr = {sr[30:0], g0_s_in};
            tick(1);
         end
         check($sformatf("g0_word%0d", f), sr, (f == 0) ? 32'h1234_5678 : 32'h9ABC_DEF0);
      end
      check("g0_frames", g0_frames, 2);
      check("g0_s_start_end", g0_s_start, 0);
      check("g0_busy", g0_busy, 0);

      // FRAMES_SENT wrap on the WIDTH=2, GAP=0 build
      tick_f(1);
      w2_data = 2'b10; w2_valid = 1'b1;
      n = 0;
      while (!w2_s_start && n < 50) begin
         tick_f(1);
         n++;
      end
      check("wrap_start_seen", w2_s_start, 1);
      check("wrap_msb", w2_s_in, 1);
      tick_f(1);
      check("wrap_lsb", w2_s_in, 0);
      tick_f(1);
      check("wrap_first", w2_frames, 1);
      tick_f(2 * 65535 - 2);
      check("wrap_ffff", w2_frames, 16'hFFFF);
      tick_f(1);
      check("wrap_hold", w2_frames, 16'hFFFF);
      tick_f(1);
      check("wrap_zero", w2_frames, 0);
      w2_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
